uart_tx_arbiter: RTL and testbench

Shares the single RS232 transmitter between two byte producers: A = CPU debug/console output, B = RX echo path. Each requester has its own small FIFO. A round-robin FSM pops one byte at a time, pulses txStart to the RS232 controller and waits for the transmit to complete. Sits between the RS232 controller's tx side and its producers; replaces the direct rxData->txData loop in the top level.

---
 rtl/uart_tx_arbiter_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_fifo.sv | 58 +++++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : uart_tx_arbiter_pkg
// Brief   : Shared state encodings and owner constants for the tx arbiter.
// Rev     : 1.0
// ---------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_START     = 2'd1;
  localparam logic [1:0] c_WAIT_BUSY = 2'd2;
  localparam logic [1:0] c_WAIT_DONE = 2'd3;

  localparam logic c_OWNER_A = 1'b0;
  localparam logic c_OWNER_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tx_byte_fifo
// Brief   : Small synchronous byte FIFO with show-ahead head output.
// Rev     : 1.0
// ---------------------------------------------------------------------------
module tx_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic [7:0] o_head
);

  localparam int             c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]  c_FULL = (c_AW+1)'(DEPTH);

  logic [7:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_AW:0]   r_count;
  logic            w_doPush;
  logic            w_doPop;

  assign o_full   = (r_count == c_FULL);
  assign o_empty  = (r_count == '0);
  assign o_head   = r_mem[r_rptr];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wptr <= r_wptr + 1'b1;
      if (w_doPop)  r_rptr <= r_rptr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : uart_tx_arbiter
// Brief   : Round-robin sharing of one RS232 transmitter between two producers.
// Rev     : 1.0
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 16,
  parameter int CNT_W         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] reqAData,
  input  logic       reqAValid,
  output logic       reqAReady,
  input  logic [7:0] reqBData,
  input  logic       reqBValid,
  output logic       reqBReady,
  output logic [7:0] txData,
  output logic       txStart,
  input  logic       txBusy,
  output logic       grantOwner,
  output logic       timeoutErr
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(START_TIMEOUT - 1);

  state_t           r_state;
  logic [7:0]       r_txData;
  logic             r_owner;
  logic             r_timeoutErr;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntInc;

  logic       w_fullA, w_emptyA, w_fullB, w_emptyB;
  logic [7:0] w_headA, w_headB;
  logic       w_pushA, w_pushB;
  logic       w_grantA, w_grantB;

  assign reqAReady = !w_fullA;
  assign reqBReady = !w_fullB;
  assign w_pushA   = reqAValid && !w_fullA;
  assign w_pushB   = reqBValid && !w_fullB;

  // On a tie the requester that did not own the previous grant wins.
  assign w_grantA = (r_state == c_IDLE) && !w_emptyA && (w_emptyB || r_owner == c_OWNER_B);
  assign w_grantB = (r_state == c_IDLE) && !w_emptyB && (w_emptyA || r_owner == c_OWNER_A);

  assign w_cntInc   = r_cnt + 1'b1;
  assign txStart    = (r_state == c_START);
  assign txData     = r_txData;
  assign grantOwner = r_owner;
  assign timeoutErr = r_timeoutErr;

  tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_pushA),
    .i_data (reqAData),
    .i_pop  (w_grantA),
    .o_full (w_fullA),
    .o_empty(w_emptyA),
    .o_head (w_headA)
  );

  tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_pushB),
    .i_data (reqBData),
    .i_pop  (w_grantB),
    .o_full (w_fullB),
    .o_empty(w_emptyB),
    .o_head (w_headB)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_txData     <= 8'h00;
      r_owner      <= c_OWNER_B;
      r_timeoutErr <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grantA) begin
            r_txData <= w_headA;
            r_owner  <= c_OWNER_A;
            r_state  <= c_START;
          end else if (w_grantB) begin
            r_txData <= w_headB;
            r_owner  <= c_OWNER_B;
            r_state  <= c_START;
          end
        end
        c_START: begin
          r_cnt   <= '0;
          r_state <= c_WAIT_BUSY;
        end
        c_WAIT_BUSY: begin
          if (txBusy) begin
            r_state <= c_WAIT_DONE;
          end else begin
            r_cnt <= w_cntInc;
            // Abandon the byte on the edge the counter reaches its last value.
            if (w_cntInc == c_LAST) begin
              r_timeoutErr <= 1'b1;
              r_state      <= c_IDLE;
            end
          end
        end
        default: begin
          if (!txBusy) r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_uart_tx_arbiter
// Brief   : Scoreboard bench; expected bytes queued at stimulus, popped on txStart.
// Rev     : 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] reqAData = 8'h00;
  logic [7:0] reqBData = 8'h00;
  logic       reqAValid = 1'b0;
  logic       reqBValid = 1'b0;
  logic       txBusy = 1'b0;
  logic       reqAReady, reqBReady, txStart, grantOwner, timeoutErr;
  logic [7:0] txData;

  int         tests = 0;
  int         fails = 0;
  int         starts = 0;
  int         busy_len = 10;
  bit         resp_en = 1'b0;
  logic [8:0] expq[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.FIFO_DEPTH(4), .START_TIMEOUT(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .reqAData  (reqAData),
    .reqAValid (reqAValid),
    .reqAReady (reqAReady),
    .reqBData  (reqBData),
    .reqBValid (reqBValid),
    .reqBReady (reqBReady),
    .txData    (txData),
    .txStart   (txStart),
    .txBusy    (txBusy),
    .grantOwner(grantOwner),
    .timeoutErr(timeoutErr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every start strobe pops one expected {owner,data} entry.
  initial begin
    logic       prev;
    logic [8:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && txStart) begin
        starts++;
        if (prev) begin
          tests++; fails++;
          $display("FAIL start_width: got 2+ cycles expected 1");
        end
        if (expq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_start: got data %0h expected no start", txData);
        end else begin
          e = expq.pop_front();
          check("tx_data", txData, e[7:0]);
          check("tx_owner", grantOwner, e[8]);
        end
      end
      prev = !rst && txStart;
    end
  end

  // RS232 model: busy rises two cycles after a start and stays for busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && !rst && txStart) begin
        repeat (2) @(posedge clk);
        #1 txBusy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 txBusy = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    txBusy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    starts = 0;
  endtask

  task automatic push(input bit useA, input bit useB, input logic [7:0] a, input logic [7:0] b);
    int g;
    g = 0;
    @(negedge clk);
    while (((useA && !reqAReady) || (useB && !reqBReady)) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      tests++; fails++;
      $display("FAIL push_ready: got ready=0 expected ready=1");
    end
    reqAValid = useA; reqAData = a;
    reqBValid = useB; reqBData = b;
    @(posedge clk);
    #1 reqAValid = 1'b0; reqBValid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int g;
    g = 0;
    while (expq.size() != 0 && g < limit) begin
      @(negedge clk);
      g++;
    end
    check("drain_empty", expq.size(), 0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int g;
    int s0;

    do_reset();
    @(negedge clk);
    check("rst_txStart", txStart, 0);
    check("rst_txData", txData, 8'h00);
    check("rst_owner", grantOwner, 1);
    check("rst_timeoutErr", timeoutErr, 0);
    check("rst_readyA", reqAReady, 1);
    check("rst_readyB", reqBReady, 1);

    // Single byte and start latency
    busy_len = 10; resp_en = 1'b1;
    expq.push_back({1'b0, 8'h41});
    push(1, 0, 8'h41, 8'h00);
    @(negedge clk);
    check("t1_no_early_start", txStart, 0);
    @(negedge clk);
    check("t1_start_latency", txStart, 1);
    drain(200);
    check("t1_start_count", starts, 1);

    // Simultaneous push: A first after reset
    do_reset();
    expq.push_back({1'b0, 8'h10});
    expq.push_back({1'b1, 8'h20});
    push(1, 1, 8'h10, 8'h20);
    drain(200);
    check("t2_start_count", starts, 2);

    // Fill A while the transmitter is held busy
    do_reset();
    resp_en = 1'b0; txBusy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      expq.push_back({1'b0, 8'(i)});
      push(1, 0, 8'(i), 8'h00);
    end
    @(negedge clk);
    check("t3_readyA_full", reqAReady, 0);
    check("t3_readyB", reqBReady, 1);
    txBusy = 1'b0; resp_en = 1'b1;
    drain(600);
    check("t3_start_count", starts, 5);

    // Strict alternation with both FIFOs loaded
    do_reset();
    resp_en = 1'b0; txBusy = 1'b1;
    expq.push_back({1'b0, 8'hA1}); expq.push_back({1'b1, 8'hB1});
    expq.push_back({1'b0, 8'hA2}); expq.push_back({1'b1, 8'hB2});
    expq.push_back({1'b0, 8'hA3}); expq.push_back({1'b1, 8'hB3});
    push(1, 1, 8'hA1, 8'hB1);
    push(1, 1, 8'hA2, 8'hB2);
    push(1, 1, 8'hA3, 8'hB3);
    @(negedge clk);
    txBusy = 1'b0; resp_en = 1'b1;
    drain(600);
    check("t4_start_count", starts, 6);

    // Start timeout, then the queued byte still goes out
    do_reset();
    resp_en = 1'b0; busy_len = 4;
    expq.push_back({1'b0, 8'h55});
    expq.push_back({1'b1, 8'h66});
    push(1, 1, 8'h55, 8'h66);
    g = 0;
    @(negedge clk);
    while (!txStart && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("t5_first_start_seen", txStart, 1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 3) resp_en = 1'b1;
      if (k == 15) check("t5_err_not_yet", timeoutErr, 0);
      if (k == 16) check("t5_err_set", timeoutErr, 1);
    end
    drain(300);
    check("t5_start_count", starts, 2);
    check("t5_err_sticky", timeoutErr, 1);

    // Reset during WAIT_DONE with bytes queued
    do_reset();
    resp_en = 1'b0; txBusy = 1'b1;
    expq.push_back({1'b0, 8'h71});
    push(1, 0, 8'h71, 8'h00);
    push(1, 0, 8'h72, 8'h00);
    push(1, 0, 8'h73, 8'h00);
    repeat (2) @(negedge clk);
    check("t6_first_sent", expq.size(), 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; txBusy = 1'b0;
    s0 = starts;
    repeat (30) @(negedge clk);
    check("t6_no_start", starts, s0);
    check("t6_txStart", txStart, 0);
    check("t6_readyA", reqAReady, 1);
    check("t6_readyB", reqBReady, 1);
    check("t6_timeoutErr", timeoutErr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
